register_file_dbg: RTL and testbench

- MIPS register file: the consumer of the write-back stage's write port, and the source of the decode stage's two operand read ports.
- Also provides a debug dump port. While the pipeline is halted, it serializes all registers byte-by-byte to the UART debug unit over a valid/ready handshake.

---
 rtl/register_file_dbg.sv | 157 +++++++++++++++
 tb/tb_register_file_dbg.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/register_file_dbg.sv
// MIPS register file: two combinational read ports with write-first bypass,
// one write port from write-back, and a halted-pipeline debug dump that
// streams every register LSB byte first over a valid/ready handshake.
// Optional: define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum byte.
module register_file_dbg #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5,
  parameter int N_REGS  = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_halt,
  input  logic               i_reg_write,
  input  logic [NB_ADDR-1:0] i_write_addr,
  input  logic [NB_DATA-1:0] i_write_data,
  input  logic [NB_ADDR-1:0] i_read_addr_a,
  input  logic [NB_ADDR-1:0] i_read_addr_b,
  output logic [NB_DATA-1:0] o_read_data_a,
  output logic [NB_DATA-1:0] o_read_data_b,
  input  logic               i_dump_start,
  input  logic               i_dump_ready,
  output logic [7:0]         o_dump_byte,
  output logic               o_dump_valid,
  output logic               o_dump_busy,
  output logic               o_dump_done
);

  localparam int N_BYTES = NB_DATA / 8;
  localparam int NB_BCNT = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [NB_BCNT-1:0] BCNT_LAST = NB_BCNT'(N_BYTES - 1);
  localparam logic [NB_ADDR-1:0] IDX_LAST  = NB_ADDR'(N_REGS - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SEND,
`ifdef REGFILE_DUMP_CHECKSUM_EN
    CKSUM,
`endif
    DONE
  } state_t;

  state_t state, state_nx;

  logic [N_REGS-1:0][NB_DATA-1:0] regs;
  logic [NB_ADDR-1:0]             idx;
  logic [NB_BCNT-1:0]             byte_cnt;
  logic [NB_DATA-1:0]             shreg;
  logic                           wr_en;
  logic                           accept;
  logic [1:0][NB_ADDR-1:0]        rd_addr;
  logic [1:0][NB_DATA-1:0]        rd_data;

  // register 0 is hardwired, and a halted pipeline must not modify state
  assign wr_en  = i_reg_write && !i_halt && (i_write_addr != '0);
  assign accept = o_dump_valid && i_dump_ready;

  // write port
  always_ff @(posedge i_clk) begin
    if (i_reset)    regs <= '0;
    else if (wr_en) regs[i_write_addr] <= i_write_data;
  end

  assign rd_addr       = {i_read_addr_b, i_read_addr_a};
  assign o_read_data_a = rd_data[0];
  assign o_read_data_b = rd_data[1];

  // read ports: write-first bypass so decode sees the value being retired
  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      if (rd_addr[p] == '0)                          rd_data[p] = '0;
      else if (wr_en && rd_addr[p] == i_write_addr)  rd_data[p] = i_write_data;
      else                                           rd_data[p] = regs[rd_addr[p]];
    end
  end

  // dump state register
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nx;
  end

  // dump next-state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (i_dump_start && i_halt) state_nx = LOAD;
      LOAD: state_nx = SEND;
      SEND: if (accept && byte_cnt == BCNT_LAST) begin
        if (idx != IDX_LAST) state_nx = LOAD;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        else                 state_nx = CKSUM;
`else
        else                 state_nx = DONE;
`endif
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      CKSUM: if (accept) state_nx = DONE;
`endif
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [7:0] cksum;

  // running XOR of every byte the sink has accepted in this dump
  always_ff @(posedge i_clk) begin
    if (i_reset)                                  cksum <= '0;
    else if (state == IDLE)                       cksum <= '0;
    else if (state == SEND && accept)             cksum <= cksum ^ o_dump_byte;
  end
`endif

  // dump datapath: register index, byte counter, snapshot of current register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      idx      <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        IDLE: idx <= '0;
        LOAD: begin
          shreg    <= regs[idx];
          byte_cnt <= '0;
        end
        SEND: if (accept) begin
          if (byte_cnt != BCNT_LAST) byte_cnt <= byte_cnt + 1'b1;
          else if (idx != IDX_LAST)  idx      <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // dump outputs decoded from state; byte is held while the sink stalls
  always_comb begin
    o_dump_valid = 1'b0;
    o_dump_byte  = '0;
    o_dump_busy  = (state != IDLE);
    o_dump_done  = (state == DONE);
    case (state)
      SEND: begin
        o_dump_valid = 1'b1;
        o_dump_byte  = shreg[{byte_cnt, 3'b000} +: 8];
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      CKSUM: begin
        o_dump_valid = 1'b1;
        o_dump_byte  = cksum;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_register_file_dbg.sv
// Directed bench for register_file_dbg: reset, read/write/bypass, halt
// blocking, full dumps with ready high and throttled, reset mid-dump.
module tb_register_file_dbg;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int N_DUMP = 129;
`else
  localparam int N_DUMP = 128;
`endif

  logic        i_clk = 0;
  logic        i_reset = 1;
  logic        i_halt = 0;
  logic        i_reg_write = 0;
  logic [4:0]  i_write_addr = '0;
  logic [31:0] i_write_data = '0;
  logic [4:0]  i_read_addr_a = '0;
  logic [4:0]  i_read_addr_b = '0;
  logic [31:0] o_read_data_a, o_read_data_b;
  logic        i_dump_start = 0;
  logic        i_dump_ready = 0;
  logic [7:0]  o_dump_byte;
  logic        o_dump_valid, o_dump_busy, o_dump_done;

  int errors = 0;
  int checks = 0;

  register_file_dbg dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_halt(i_halt),
    .i_reg_write(i_reg_write), .i_write_addr(i_write_addr), .i_write_data(i_write_data),
    .i_read_addr_a(i_read_addr_a), .i_read_addr_b(i_read_addr_b),
    .o_read_data_a(o_read_data_a), .o_read_data_b(o_read_data_b),
    .i_dump_start(i_dump_start), .i_dump_ready(i_dump_ready),
    .o_dump_byte(o_dump_byte), .o_dump_valid(o_dump_valid),
    .o_dump_busy(o_dump_busy), .o_dump_done(o_dump_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // byte k of the dump for the preload reg[i] = i*0x01010101; checksum is 0
  function automatic logic [31:0] exp_byte(input int k);
    return (k < 128) ? 32'(k / 4) : 32'h0;
  endfunction

  task automatic preload();
    i_halt = 0;
    for (int i = 1; i < 32; i++) begin
      i_reg_write = 1; i_write_addr = 5'(i); i_write_data = 32'(i) * 32'h01010101;
      step();
    end
    i_reg_write = 0;
  endtask

  // stop_at < 0: run to completion and check the done pulse
  task automatic run_dump(input bit rnd, input int stop_at);
    int nb, ndone, cyc;
    bit hold;
    logic [7:0] held;
    nb = 0; ndone = 0; hold = 0; held = '0;
    i_dump_ready = 0;
    i_dump_start = 1;
    step();
    i_dump_start = 0;
    #1;
    chk("load_busy", 32'(o_dump_busy), 1);
    chk("load_valid", 32'(o_dump_valid), 0);
    step();
    chk("first_valid", 32'(o_dump_valid), 1);
    for (cyc = 0; cyc < 3000; cyc++) begin
      i_dump_ready = rnd ? (((cyc % 37) < 10) ? 1'b0 : 1'($urandom_range(0, 1))) : 1'b1;
      #1;
      if (ndone > 0 && !o_dump_done) begin
        chk("post_busy", 32'(o_dump_busy), 0);
        chk("post_valid", 32'(o_dump_valid), 0);
        break;
      end
      if (hold) begin
        chk("hold_valid", 32'(o_dump_valid), 1);
        chk("hold_byte", 32'(o_dump_byte), 32'(held));
      end
      if (o_dump_done) ndone++;
      if (o_dump_valid) begin
        chk($sformatf("byte%0d", nb), 32'(o_dump_byte), exp_byte(nb));
        if (i_dump_ready) begin nb++; hold = 0; end
        else begin hold = 1; held = o_dump_byte; end
      end
      step();
      if (stop_at >= 0 && nb >= stop_at) break;
    end
    i_dump_ready = 0;
    chk("dump_timeout", 32'(cyc < 3000), 1);
    if (stop_at < 0) begin
      chk("byte_count", 32'(nb), 32'(N_DUMP));
      chk("done_pulses", 32'(ndone), 1);
    end
  endtask

  initial begin
    // reset
    step(); step();
    i_reset = 0;
    #1;
    chk("rst_valid", 32'(o_dump_valid), 0);
    chk("rst_busy", 32'(o_dump_busy), 0);
    chk("rst_done", 32'(o_dump_done), 0);
    chk("rst_byte", 32'(o_dump_byte), 0);
    step();
    for (int a = 0; a < 32; a++) begin
      i_read_addr_a = 5'(a); i_read_addr_b = 5'(31 - a);
      #1;
      chk($sformatf("rst_rd_a%0d", a), o_read_data_a, 0);
      chk($sformatf("rst_rd_b%0d", 31 - a), o_read_data_b, 0);
      step();
    end

    // writes to reg 0 discarded, no bypass on address 0
    i_reg_write = 1; i_write_addr = 0; i_write_data = 32'hDEADBEEF; i_read_addr_a = 0;
    #1 chk("r0_bypass", o_read_data_a, 0);
    step();
    i_reg_write = 0;
    #1 chk("r0_after", o_read_data_a, 0);
    step();

    // write-first bypass on port A, stored value on port B after the edge
    i_reg_write = 1; i_write_addr = 5; i_write_data = 32'h12345678;
    i_read_addr_a = 5; i_read_addr_b = 6;
    #1;
    chk("byp_a", o_read_data_a, 32'h12345678);
    chk("byp_b_other", o_read_data_b, 0);
    step();
    i_reg_write = 0; i_read_addr_b = 5;
    #1 chk("r5_b", o_read_data_b, 32'h12345678);
    step();

    // both ports bypass together
    i_reg_write = 1; i_write_addr = 9; i_write_data = 32'hCAFEF00D;
    i_read_addr_a = 9; i_read_addr_b = 9;
    #1;
    chk("byp2_a", o_read_data_a, 32'hCAFEF00D);
    chk("byp2_b", o_read_data_b, 32'hCAFEF00D);
    step();
    i_reg_write = 0;

    // halt blocks writes and bypass
    i_halt = 1; i_reg_write = 1; i_write_addr = 7; i_write_data = 32'hAAAA5555; i_read_addr_a = 7;
    #1 chk("halt_nobyp", o_read_data_a, 0);
    step();
    i_reg_write = 0;
    #1 chk("halt_nowr", o_read_data_a, 0);
    step();
    i_halt = 0; i_reg_write = 1;
    step();
    i_reg_write = 0;
    #1 chk("unhalt_wr", o_read_data_a, 32'hAAAA5555);
    step();

    // dump request ignored when not halted
    i_dump_start = 1;
    step();
    i_dump_start = 0;
    #1 chk("start_nohalt", 32'(o_dump_busy), 0);
    step();

    // full dump, ready held high
    preload();
    i_halt = 1;
    step();
    run_dump(0, -1);

    // throttled dump: same stream, byte held during stalls
    run_dump(1, -1);

    // reset in the middle of a dump
    run_dump(0, 10);
    i_reset = 1;
    step();
    i_reset = 0;
    #1;
    chk("mid_rst_valid", 32'(o_dump_valid), 0);
    chk("mid_rst_busy", 32'(o_dump_busy), 0);
    chk("mid_rst_byte", 32'(o_dump_byte), 0);
    step();
    for (int a = 1; a < 32; a += 6) begin
      i_read_addr_a = 5'(a); i_read_addr_b = 5'(a + 1);
      #1;
      chk($sformatf("mid_rst_rd%0d", a), o_read_data_a, 0);
      chk($sformatf("mid_rst_rd%0d", a + 1), o_read_data_b, 0);
      step();
    end

    // a fresh dump starts from register 0
    preload();
    i_halt = 1;
    step();
    run_dump(1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
